// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU package: mode encodings, instruction field positions, fetch state enum
package cpu_pkg;

    localparam logic [1:0] MODE_JUMP  = 2'b00;
    localparam logic [1:0] MODE_LOAD  = 2'b01;
    localparam logic [1:0] MODE_STORE = 2'b10;
    localparam logic [1:0] MODE_ALU   = 2'b11;

    localparam int INSTR_WIDTH = 8;
    localparam int MODE_MSB    = 7;
    localparam int MODE_LSB    = 6;
    localparam int RS_MSB      = 5;
    localparam int RS_LSB      = 4;
    localparam int RT_MSB      = 3;
    localparam int RT_LSB      = 2;
    localparam int OPC_MSB     = 1;
    localparam int OPC_LSB     = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

    // The 2-bit immediate lives in the opcode field and is treated as signed.
    function automatic logic [7:0] sext_imm(input logic [1:0] field);
        return {{6{field[1]}}, field};
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - instruction memory request/ready port
interface instruction_fetch_if #(
    parameter int PC_WIDTH = 8
);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_ready;
    logic [7:0]          imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/ifetch_prefetch_buf.sv
// rtl/ifetch_prefetch_buf.sv - one-entry prefetch buffer holding the byte fetched for pc_out+1
module ifetch_prefetch_buf #(
    parameter int PC_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                fill,
    input  logic [7:0]          fill_data,
    input  logic [PC_WIDTH-1:0] fill_pc,
    input  logic                flush,
    output logic                valid,
    output logic [7:0]          data,
    output logic [PC_WIDTH-1:0] pc
);

    // A consume always empties the entry; fills only happen when no consume is taking the byte directly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (fill) begin
            valid <= 1'b1;
            data  <= fill_data;
            pc    <= fill_pc;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC, imem handshake, IR and field split; optional IFETCH_PREFETCH_EN
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset_n,
    instruction_fetch_if.master imem,
    input  logic                stall,
    input  logic                jump_taken,
    input  logic [PC_WIDTH-1:0] jump_target,
    output logic                ir_valid,
    output logic [1:0]          mode,
    output logic [1:0]          rs,
    output logic [1:0]          rt,
    output logic [1:0]          opcode,
    output logic [7:0]          imm,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic [PC_WIDTH-1:0] pc_next
);

    fetch_state_t               state_q, state_d;
    logic [PC_WIDTH-1:0]        pc_q, pc_d;
    logic [INSTR_WIDTH-1:0]     ir_q, ir_d;
    logic [PC_WIDTH-1:0]        pc_out_q, pc_out_d;
    logic                       ir_valid_q, ir_valid_d;
    logic [PC_WIDTH-1:0]        pc_inc;
    logic                       consume;

    assign pc_inc  = pc_out_q + PC_WIDTH'(1);
    assign consume = ir_valid_q && !stall;

`ifdef IFETCH_PREFETCH_EN
    logic                discard_q, discard_d;
    logic [PC_WIDTH-1:0] discard_addr_q, discard_addr_d;
    logic                buf_fill, buf_flush, buf_valid;
    logic [7:0]          buf_data;
    logic [PC_WIDTH-1:0] buf_pc;

    ifetch_prefetch_buf #(
        .PC_WIDTH (PC_WIDTH)
    ) u_pf_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .fill      (buf_fill),
        .fill_data (imem.imem_rdata),
        .fill_pc   (pc_inc),
        .flush     (buf_flush),
        .valid     (buf_valid),
        .data      (buf_data),
        .pc        (buf_pc)
    );

    // Tracks a prefetch that was still pending at a jump: it must finish its handshake before the target fetch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            discard_q      <= 1'b0;
            discard_addr_q <= '0;
        end else begin
            discard_q      <= discard_d;
            discard_addr_q <= discard_addr_d;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, datapath next values and the combinational memory request.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        ir_d           = ir_q;
        pc_out_d       = pc_out_q;
        ir_valid_d     = ir_valid_q;
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc_q;
`ifdef IFETCH_PREFETCH_EN
        discard_d      = discard_q;
        discard_addr_d = discard_addr_q;
        buf_fill       = 1'b0;
        buf_flush      = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem.imem_req = 1'b1;
`ifdef IFETCH_PREFETCH_EN
                if (discard_q) begin
                    imem.imem_addr = discard_addr_q;
                    if (imem.imem_ready) begin
                        discard_d = 1'b0;
                    end
                end else if (imem.imem_ready) begin
                    ir_d       = imem.imem_rdata;
                    pc_out_d   = pc_q;
                    ir_valid_d = 1'b1;
                    state_d    = ST_HOLD;
                end
`else
                if (imem.imem_ready) begin
                    ir_d       = imem.imem_rdata;
                    pc_out_d   = pc_q;
                    ir_valid_d = 1'b1;
                    state_d    = ST_HOLD;
                end
`endif
            end
            ST_HOLD: begin
`ifdef IFETCH_PREFETCH_EN
                imem.imem_req  = !buf_valid;
                imem.imem_addr = pc_inc;
                buf_fill       = imem.imem_req && imem.imem_ready && !consume;
                buf_flush      = consume;
                if (consume) begin
                    if (jump_taken) begin
                        pc_d       = jump_target;
                        ir_valid_d = 1'b0;
                        state_d    = ST_FETCH;
                        if (imem.imem_req && !imem.imem_ready) begin
                            discard_d      = 1'b1;
                            discard_addr_d = pc_inc;
                        end
                    end else if (buf_valid) begin
                        ir_d     = buf_data;
                        pc_out_d = buf_pc;
                    end else if (imem.imem_req && imem.imem_ready) begin
                        ir_d     = imem.imem_rdata;
                        pc_out_d = pc_inc;
                    end else begin
                        // Pending prefetch carries on as the FETCH request at the same address.
                        pc_d       = pc_inc;
                        ir_valid_d = 1'b0;
                        state_d    = ST_FETCH;
                    end
                end
`else
                if (consume) begin
                    pc_d       = jump_taken ? jump_target : pc_inc;
                    ir_valid_d = 1'b0;
                    state_d    = ST_FETCH;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath registers: PC, IR, address of the held instruction and its valid flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            pc_out_q   <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            pc_out_q   <= pc_out_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    assign ir_valid = ir_valid_q;
    assign mode     = ir_q[MODE_MSB:MODE_LSB];
    assign rs       = ir_q[RS_MSB:RS_LSB];
    assign rt       = ir_q[RT_MSB:RT_LSB];
    assign opcode   = ir_q[OPC_MSB:OPC_LSB];
    assign imm      = sext_imm(ir_q[OPC_MSB:OPC_LSB]);
    assign pc_out   = pc_out_q;
    assign pc_next  = pc_inc;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the 8-bit processor: owns the program counter, requests instruction bytes from instruction memory over a ready-handshaked port, and holds the current instruction in a register. It splits the instruction into the `mode`, `opcode`, register and immediate fields that the downstream control decoder and datapath consume. Jumps are redirected into the PC from the execute side.

## Interface
- `PC_WIDTH`, 8, width of PC and instruction-memory address
- `RESET_PC`, 0, PC value loaded at reset
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous active-low reset
- `imem_req`  out  1  fetch request; held until accepted
- `imem_addr`  out  PC_WIDTH  fetch address; stable while `imem_req`=1
- `imem_ready`  in  1  memory accepts request and returns data this cycle
- `imem_rdata`  in  8  instruction byte; valid when `imem_req && imem_ready`
- `stall`  in  1  downstream cannot consume the held instruction this cycle
- `jump_taken`  in  1  downstream redirects PC; sampled only on a consume cycle
- `jump_target`  in  PC_WIDTH  redirect address
- `ir_valid`  out  1  held instruction valid
- `mode`  out  2  instr[7:6]
- `rs`  out  2  instr[5:4]
- `rt`  out  2  instr[3:2]
- `opcode`  out  2  instr[1:0], also the destination/immediate field
- `imm`  out  8  instr[1:0] sign-extended to 8 bits
- `pc_out`  out  PC_WIDTH  address of held instruction
- `pc_next`  out  PC_WIDTH  `pc_out + 1`, modulo 2^PC_WIDTH

## Operation
- States: IDLE, FETCH, HOLD.
- IDLE: entered on reset, left unconditionally on the first clock edge. `imem_req` is 0.
- FETCH: `imem_req`=1 and `imem_addr`=PC. On `imem_ready`, capture `imem_rdata` into IR and PC into `pc_out`, then go to HOLD.
- HOLD: `ir_valid`=1. A consume occurs when `ir_valid && !stall`.
  - Consume with `jump_taken`=1: PC <= `jump_target`.
  - Consume without `jump_taken`: PC <= `pc_out + 1`.
  - In both cases, go to FETCH.
- `jump_taken` is ignored when no consume occurs.
- PC increment wraps: 0xFF+1 = 0x00 at `PC_WIDTH`=8.
- `imem_req` and `imem_addr` are decoded combinationally from state and PC. All other outputs are registered.
- The field outputs are always driven from IR. They are meaningful only while `ir_valid`=1.
- Reset values: state=IDLE, PC=`RESET_PC`, IR=0, `pc_out`=0, `ir_valid`=0, `imem_req`=0, all fields 0, `imm`=0.
- Reset asserted mid-fetch abandons the request with no handshake. Instruction memory must tolerate the dropped request.

## Timing
- After reset release, FETCH begins 1 cycle later.
- Fetch latency with zero-wait memory: `imem_ready` in the first FETCH cycle gives `ir_valid` on the next edge.
- Without prefetch, throughput is at most 1 instruction per 2 cycles.
- `ir_valid` falls on the edge after a consume.
- `stall`=1 holds IR, `pc_out` and `ir_valid` unchanged indefinitely.

## Configuration
- `IFETCH_PREFETCH_EN` defined:
  - A one-entry prefetch buffer fetches `pc_out+1` while in HOLD.
  - A consume without jump with the buffer full loads IR from the buffer in the same edge, keeping `ir_valid`=1, so back-to-back instructions issue 1 per cycle.
  - `jump_taken` on a consume flushes the buffer.
  - A prefetch outstanding at jump time completes its handshake and is discarded. The target fetch is then issued.
  - A buffer fill and a consume on the same edge go straight to IR.
- `IFETCH_PREFETCH_EN` undefined: the strict FETCH/HOLD alternation above applies, and no memory request is issued in HOLD.

## Structure
- Shared package `cpu_pkg` holds:
  - Mode encodings: `MODE_JUMP`=2'b00, `MODE_LOAD`=2'b01, `MODE_STORE`=2'b10, `MODE_ALU`=2'b11.
  - Instruction field bit positions.
  - The fetch state enum.
- Sub-module `ifetch_prefetch_buf` (data, pc, valid, flush) is instantiated only under `IFETCH_PREFETCH_EN`.

## Test plan
- Reset → `RESET_PC`=0x10. Release with `imem_ready`=1 and rdata 0xE6 → `imem_addr`=0x10, then `ir_valid`=1, `mode`=11, `rs`=10, `rt`=01, `opcode`=10, `imm`=0xFE.
- Memory wait: `imem_ready` low for 3 cycles → `imem_req`/`imem_addr` stable for 4 cycles, and IR captured only on the ready cycle.
- `stall`=1 for 5 cycles with `jump_taken`=1 pulsed → IR unchanged and no redirect. Release with `jump_taken`=0 → next `imem_addr`=`pc_out`+1.
- Consume with `jump_taken`=1 and `jump_target`=0x40 → next `imem_addr`=0x40, `pc_out`=0x40. With prefetch enabled, the prefetched byte from 0x11 never appears in IR.
- PC 0xFF consumed without jump → next fetch from 0x00, `pc_next` shown as 0x00 while at 0xFF.
- `reset_n` asserted while `imem_req`=1 → all outputs return to reset values immediately, without waiting for a clock edge.
